// File: rtl/seg_pkg.sv
// Shared constants and types for the seven-segment readback path.
// Segment patterns are active-low with bit0=a ... bit6=g.
package seg_pkg;

    localparam logic [6:0] SEG_0     = 7'b1000000;
    localparam logic [6:0] SEG_1     = 7'b1111001;
    localparam logic [6:0] SEG_2     = 7'b0100100;
    localparam logic [6:0] SEG_3     = 7'b0110000;
    localparam logic [6:0] SEG_4     = 7'b0011001;
    localparam logic [6:0] SEG_5     = 7'b0010010;
    localparam logic [6:0] SEG_6     = 7'b0000010;
    localparam logic [6:0] SEG_7     = 7'b1111000;
    localparam logic [6:0] SEG_8     = 7'b0000000;
    localparam logic [6:0] SEG_9     = 7'b0010000;
    localparam logic [6:0] SEG_BLANK = 7'b1111111;
    localparam logic [6:0] SEG_A     = 7'b0001000;
    localparam logic [6:0] SEG_B     = 7'b0000011;
    localparam logic [6:0] SEG_C     = 7'b1000110;
    localparam logic [6:0] SEG_D     = 7'b0100001;
    localparam logic [6:0] SEG_E     = 7'b0000110;
    localparam logic [6:0] SEG_F     = 7'b0001110;

    typedef struct packed {
        logic [3:0] code;
        logic       blank;
        logic       err;
    } slot_t;

    typedef enum logic {
        WAIT,
        LOCKED
    } state_t;

endpackage

// File: rtl/seg_pattern_to_digit.sv
// Combinational segment-pattern to code/blank/err lookup.
// Hex letters A..F are recognised only when SEG_HEX_DECODE_EN is defined.
module seg_pattern_to_digit
    import seg_pkg::*;
(
    input  logic [6:0] i_seg,
    output slot_t      o_result
);

    always_comb begin
        o_result = '{code: 4'd0, blank: 1'b0, err: 1'b0};
        case (i_seg)
            SEG_0:     o_result.code = 4'd0;
            SEG_1:     o_result.code = 4'd1;
            SEG_2:     o_result.code = 4'd2;
            SEG_3:     o_result.code = 4'd3;
            SEG_4:     o_result.code = 4'd4;
            SEG_5:     o_result.code = 4'd5;
            SEG_6:     o_result.code = 4'd6;
            SEG_7:     o_result.code = 4'd7;
            SEG_8:     o_result.code = 4'd8;
            SEG_9:     o_result.code = 4'd9;
            SEG_BLANK: o_result.blank = 1'b1;
`ifdef SEG_HEX_DECODE_EN
            SEG_A:     o_result.code = 4'd10;
            SEG_B:     o_result.code = 4'd11;
            SEG_C:     o_result.code = 4'd12;
            SEG_D:     o_result.code = 4'd13;
            SEG_E:     o_result.code = 4'd14;
            SEG_F:     o_result.code = 4'd15;
`endif
            default:   o_result.err = 1'b1;
        endcase
    end

endmodule

// File: rtl/seg_scan_capture.sv
// Recovers digit codes from a multiplexed active-low seven-segment bus and
// presents complete frames on a valid/ready output. Hex decode: SEG_HEX_DECODE_EN.
module seg_scan_capture
    import seg_pkg::*;
#(
    parameter int NUM_DIGITS    = 4,
    parameter int STABLE_CYCLES = 8
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [6:0]              seg_in,
    input  logic [NUM_DIGITS-1:0]   an_in,
    output logic [4*NUM_DIGITS-1:0] out_digits,
    output logic [NUM_DIGITS-1:0]   out_blank,
    output logic [NUM_DIGITS-1:0]   out_err,
    output logic                    out_valid,
    input  logic                    out_ready
);

    localparam logic [7:0] CNT_MAX = 8'(STABLE_CYCLES - 1);

    logic [6:0]              r_seg;
    logic [NUM_DIGITS-1:0]   r_an;
    logic [7:0]              r_cnt;
    state_t                  r_state;
    state_t                  w_nextState;
    logic                    w_changed;
    logic                    w_stable;
    logic [NUM_DIGITS-1:0]   w_anLow;
    logic                    w_anValid;
    logic                    w_capture;
    slot_t                   w_decoded;
    slot_t                   r_slots [NUM_DIGITS];
    logic [NUM_DIGITS-1:0]   r_seen;
    logic                    w_load;
    logic [4*NUM_DIGITS-1:0] r_outDigits;
    logic [NUM_DIGITS-1:0]   r_outBlank;
    logic [NUM_DIGITS-1:0]   r_outErr;
    logic                    r_outValid;

    assign w_changed = (seg_in != r_seg) || (an_in != r_an);
    assign w_stable  = (r_cnt == CNT_MAX);
    assign w_anLow   = ~r_an;
    assign w_anValid = (w_anLow != '0) &&
                       ((w_anLow & (w_anLow - NUM_DIGITS'(1))) == '0);
    assign w_load    = (&r_seen) && (!r_outValid || out_ready);

    seg_pattern_to_digit u_decode (
        .i_seg    (r_seg),
        .o_result (w_decoded)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_seg <= '0;
            r_an  <= '0;
            r_cnt <= '0;
        end else begin
            r_seg <= seg_in;
            r_an  <= an_in;
            if (w_changed)
                r_cnt <= '0;
            else if (!w_stable)
                r_cnt <= r_cnt + 8'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n)
            r_state <= WAIT;
        else
            r_state <= w_nextState;
    end

    // A capture whose input changes on the same edge must stay in WAIT so the
    // new value can still be captured once it settles.
    always_comb begin
        w_nextState = r_state;
        case (r_state)
            WAIT:    if (w_stable && w_anValid && !w_changed) w_nextState = LOCKED;
            LOCKED:  if (w_changed) w_nextState = WAIT;
            default: w_nextState = WAIT;
        endcase
    end

    always_comb begin
        w_capture = (r_state == WAIT) && w_stable && w_anValid;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_seen <= '0;
            for (int i = 0; i < NUM_DIGITS; i++)
                r_slots[i] <= '0;
        end else begin
            r_seen <= (w_load ? '0 : r_seen) | (w_capture ? w_anLow : '0);
            for (int i = 0; i < NUM_DIGITS; i++)
                if (w_capture && w_anLow[i])
                    r_slots[i] <= w_decoded;
        end
    end

    // A pending frame loads as soon as the output register is free or being drained.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_outDigits <= '0;
            r_outBlank  <= '0;
            r_outErr    <= '0;
            r_outValid  <= 1'b0;
        end else if (w_load) begin
            for (int i = 0; i < NUM_DIGITS; i++) begin
                r_outDigits[4*i +: 4] <= r_slots[i].code;
                r_outBlank[i]         <= r_slots[i].blank;
                r_outErr[i]           <= r_slots[i].err;
            end
            r_outValid <= 1'b1;
        end else if (r_outValid && out_ready) begin
            r_outValid <= 1'b0;
        end
    end

    assign out_digits = r_outDigits;
    assign out_blank  = r_outBlank;
    assign out_err    = r_outErr;
    assign out_valid  = r_outValid;

endmodule

// File: tb/tb_seg_scan_capture.sv
// Scoreboard bench for seg_scan_capture: expected frames are queued by the
// stimulus and popped by a monitor on every output handshake.
module tb_seg_scan_capture;

    localparam logic [6:0] P0    = 7'b1000000;
    localparam logic [6:0] P1    = 7'b1111001;
    localparam logic [6:0] P2    = 7'b0100100;
    localparam logic [6:0] P3    = 7'b0110000;
    localparam logic [6:0] P4    = 7'b0011001;
    localparam logic [6:0] P5    = 7'b0010010;
    localparam logic [6:0] P6    = 7'b0000010;
    localparam logic [6:0] P7    = 7'b1111000;
    localparam logic [6:0] P8    = 7'b0000000;
    localparam logic [6:0] P9    = 7'b0010000;
    localparam logic [6:0] PBLNK = 7'b1111111;
    localparam logic [6:0] PERR  = 7'b0111111;
    localparam logic [6:0] PHEXE = 7'b0000110;

    typedef struct packed {
        logic [15:0] digits;
        logic [3:0]  blank;
        logic [3:0]  err;
    } frame_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [6:0]  seg_in;
    logic [3:0]  an_in;
    logic [15:0] out_digits;
    logic [3:0]  out_blank;
    logic [3:0]  out_err;
    logic        out_valid;
    logic        out_ready;

    frame_t expQ[$];
    int     checkCount = 0;
    int     passCount  = 0;

    always #5 clk = ~clk;

    seg_scan_capture #(
        .NUM_DIGITS    (4),
        .STABLE_CYCLES (8)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .seg_in     (seg_in),
        .an_in      (an_in),
        .out_digits (out_digits),
        .out_blank  (out_blank),
        .out_err    (out_err),
        .out_valid  (out_valid),
        .out_ready  (out_ready)
    );

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        checkCount++;
        if (actual === expected)
            passCount++;
        else
            $display("[TB] FAIL %s: actual=%0h required=%0h", name, actual, expected);
    endtask

    // Monitor: every accepted frame must match the oldest queued expectation.
    always @(negedge clk) begin
        frame_t e;
        if (rst_n === 1'b1 && out_valid === 1'b1 && out_ready === 1'b1) begin
            if (expQ.size() == 0) begin
                checkCount++;
                $display("[TB] FAIL unexpected_frame: actual=%h required=none", out_digits);
            end else begin
                e = expQ.pop_front();
                checkOutput("frame_digits", 32'(out_digits), 32'(e.digits));
                checkOutput("frame_blank", 32'(out_blank), 32'(e.blank));
                checkOutput("frame_err", 32'(out_err), 32'(e.err));
            end
        end
    end

    task automatic holdCycles(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic setInputs(input int pos, input logic [6:0] seg);
        seg_in = seg;
        an_in  = ~(4'b0001 << pos);
    endtask

    task automatic applyStimulus(input int pos, input logic [6:0] seg, input int cycles);
        setInputs(pos, seg);
        holdCycles(cycles);
    endtask

    task automatic driveFrame(input logic [6:0] s0, input logic [6:0] s1,
                              input logic [6:0] s2, input logic [6:0] s3);
        applyStimulus(0, s0, 12);
        applyStimulus(1, s1, 12);
        applyStimulus(2, s2, 12);
        applyStimulus(3, s3, 12);
    endtask

    initial begin
        rst_n     = 1'b0;
        seg_in    = PBLNK;
        an_in     = 4'hF;
        out_ready = 1'b0;
        holdCycles(3);
        checkOutput("reset_valid", 32'(out_valid), 32'd0);
        checkOutput("reset_digits", 32'(out_digits), 32'd0);
        checkOutput("reset_blank", 32'(out_blank), 32'd0);
        checkOutput("reset_err", 32'(out_err), 32'd0);
        rst_n = 1'b1;
        holdCycles(1);

        // Stable frame 3,1,4,1 with exact valid-pulse timing.
        out_ready = 1'b1;
        expQ.push_back(frame_t'{16'h1413, 4'h0, 4'h0});
        applyStimulus(0, P3, 12);
        applyStimulus(1, P1, 12);
        applyStimulus(2, P4, 12);
        setInputs(3, P1);
        holdCycles(9);
        checkOutput("stable_valid_capture_edge", 32'(out_valid), 32'd0);
        holdCycles(1);
        checkOutput("stable_valid_load_edge", 32'(out_valid), 32'd1);
        holdCycles(1);
        checkOutput("stable_valid_after_accept", 32'(out_valid), 32'd0);
        holdCycles(2);

        // Glitch rejection on slot 0 with slots 1..3 already seen.
        out_ready = 1'b0;
        expQ.push_back(frame_t'{16'h9025, 4'h0, 4'h0});
        applyStimulus(1, P2, 12);
        applyStimulus(2, P0, 12);
        applyStimulus(3, P9, 12);
        for (int g = 0; g < 8; g++) begin
            applyStimulus(0, P5, 4);
            applyStimulus(0, P6, 1);
        end
        checkOutput("glitch_no_capture", 32'(out_valid), 32'd0);
        setInputs(0, P5);
        holdCycles(9);
        checkOutput("glitch_capture_edge", 32'(out_valid), 32'd0);
        holdCycles(1);
        checkOutput("glitch_frame_loaded", 32'(out_valid), 32'd1);
        out_ready = 1'b1;
        holdCycles(2);

        // Hex letter E in slot 0.
`ifdef SEG_HEX_DECODE_EN
        expQ.push_back(frame_t'{16'h107E, 4'h0, 4'h0});
`else
        expQ.push_back(frame_t'{16'h1070, 4'h0, 4'h1});
`endif
        driveFrame(PHEXE, P7, P0, P1);
        holdCycles(3);

        // Backpressure: first frame held while a second completes behind it.
        out_ready = 1'b0;
        expQ.push_back(frame_t'{16'h6789, 4'h0, 4'h0});
        driveFrame(P9, P8, P7, P6);
        checkOutput("bp_first_valid", 32'(out_valid), 32'd1);
        checkOutput("bp_first_digits", 32'(out_digits), 32'h6789);
        expQ.push_back(frame_t'{16'h0000, 4'h0, 4'h0});
        driveFrame(P0, P0, P0, P0);
        holdCycles(2);
        checkOutput("bp_held_valid", 32'(out_valid), 32'd1);
        checkOutput("bp_held_digits", 32'(out_digits), 32'h6789);
        out_ready = 1'b1;
        holdCycles(1);
        out_ready = 1'b0;
        checkOutput("bp_b2b_valid", 32'(out_valid), 32'd1);
        checkOutput("bp_b2b_digits", 32'(out_digits), 32'h0000);
        out_ready = 1'b1;
        holdCycles(2);

        // Blank/error frame left pending, then reset mid-frame.
        out_ready = 1'b0;
        driveFrame(P8, PERR, PBLNK, P2);
        holdCycles(1);
        checkOutput("blank_valid", 32'(out_valid), 32'd1);
        checkOutput("blank_digits", 32'(out_digits), 32'h2008);
        checkOutput("blank_mask", 32'(out_blank), 32'b0100);
        checkOutput("err_mask", 32'(out_err), 32'b0010);
        applyStimulus(0, P3, 12);
        applyStimulus(1, P3, 12);
        seg_in = P3;
        an_in  = 4'hF;
        holdCycles(2);
        rst_n = 1'b0;
        holdCycles(1);
        rst_n = 1'b1;
        checkOutput("midreset_valid", 32'(out_valid), 32'd0);
        checkOutput("midreset_digits", 32'(out_digits), 32'd0);
        checkOutput("midreset_blank", 32'(out_blank), 32'd0);
        checkOutput("midreset_err", 32'(out_err), 32'd0);

        out_ready = 1'b1;
        expQ.push_back(frame_t'{16'h5476, 4'h0, 4'h0});
        applyStimulus(2, P4, 12);
        applyStimulus(3, P5, 12);
        holdCycles(2);
        checkOutput("postreset_partial_valid", 32'(out_valid), 32'd0);
        applyStimulus(0, P6, 12);
        applyStimulus(1, P7, 12);
        holdCycles(3);

        for (int i = 0; i < 200 && expQ.size() != 0; i++)
            @(posedge clk);
        #2;
        checkOutput("scoreboard_drained", 32'(expQ.size()), 32'd0);

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
